// File: rtl/fpga_input_pkg.sv
// Shared types and defaults for the board-input controller.
// Holds the handshake FSM state encoding and the button-id width helper.
package fpga_input_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StHold
    } ctrl_state_e;

    localparam int unsigned DefDataW          = 16;
    localparam int unsigned DefNBtn           = 4;
    localparam int unsigned DefDebounceCycles = 50000;
    localparam int unsigned DefSyncStages     = 2;

    // A single button still needs a 1-bit id port.
    function automatic int unsigned id_width(int unsigned n_btn);
        return (n_btn > 1) ? $clog2(n_btn) : 1;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// One push button: synchroniser, debounced stable level and a registered press pulse.
// Levels are active-low; a press is the stable level falling 1->0.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic                   stable_prev_q;
    logic                   press_q;
    logic [CntW-1:0]        cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter only survives consecutive differing cycles, so it tops out
    // at DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (synced != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], button};
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_prev_q & ~stable_q;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/fpga_input_ctrl.sv
// Board-input controller: synchronised switch bank, N debounced buttons and a
// request/confirm handshake that snapshots the switches on a button press.
module fpga_input_ctrl
    import fpga_input_pkg::*;
#(
    parameter int unsigned DATA_W          = DefDataW,
    parameter int unsigned N_BTN           = DefNBtn,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    localparam int unsigned ID_W           = id_width(N_BTN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] switches,
    input  logic [N_BTN-1:0]  buttons,
    input  logic              input_req,
    output logic [DATA_W-1:0] input_data,
    output logic              input_valid,
    output logic [ID_W-1:0]   input_btn_id,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  btn_press
);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q;
    logic [DATA_W-1:0]                  sw_synced;
    logic [ID_W-1:0]                    press_id;
    ctrl_state_e                        state_q, state_d;
    logic [DATA_W-1:0]                  data_q, data_d;
    logic [ID_W-1:0]                    id_q, id_d;
    logic                               valid_q, valid_d;

    assign sw_synced = sw_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_sync_q <= '0;
        end else begin
            sw_sync_q[0] <= switches;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sw_sync_q[i] <= sw_sync_q[i-1];
            end
        end
    end

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_btn
        input_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk     (clk),
            .reset_n (reset_n),
            .button  (buttons[g]),
            .level   (btn_level[g]),
            .press   (btn_press[g])
        );
    end

    // Descending scan so the lowest pressing index is the last to write.
    always_comb begin
        press_id = '0;
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (btn_press[i]) begin
                press_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        valid_d = valid_q;
        case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (input_req) begin
                    state_d = StWaitPress;
                end
            end
            StWaitPress: begin
                // A request drop beats a press landing on the same edge.
                if (!input_req) begin
                    state_d = StIdle;
                end else if (|btn_press) begin
                    data_d  = sw_synced;
                    id_d    = press_id;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!input_req) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign input_data   = data_q;
    assign input_btn_id = id_q;
    assign input_valid  = valid_q;

endmodule
